gt_tx_seq_ctrl: RTL and testbench



---
 rtl/gt_tx_seq_ctrl.sv | 92 +++++++++
 tb/tb_gt_tx_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_tx_seq_ctrl.sv
// TX gearbox sequencer: drives the external sequence count, stalls the word stream
// on the gearbox pause cycle through a 2-deep FIFO, and fills empty slots with idle blocks.
module gt_tx_seq_ctrl #(
  parameter int          SEQ_MAX     = 32,
  parameter logic [63:0] IDLE_DATA   = 64'h1E00_0000_0000_0000,
  parameter logic [1:0]  IDLE_HEADER = 2'b10,
  parameter int          CNT_W       = 16
) (
  input  logic             USER_CLK,
  input  logic             SYSTEM_RESET_N,
  input  logic             ENABLE,
  input  logic [63:0]      S_DATA,
  input  logic [1:0]       S_HEADER,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [63:0]      TX_DATA,
  output logic [1:0]       TX_HEADER,
  output logic [6:0]       TX_SEQUENCE,
  output logic [CNT_W-1:0] IDLE_CNT
);

  localparam logic [6:0] SEQ_MAX7 = 7'(SEQ_MAX);

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } word_t;

  localparam word_t IDLE_WORD = '{hdr: IDLE_HEADER, data: IDLE_DATA};

  logic [6:0]       seq_q, seq_d;
  logic [1:0]       cnt_q, cnt_d, wr_lvl;
  logic             rdy_q, rdy_d;
  word_t            buf_q [2];
  word_t            buf_d [2];
  word_t            tx_q, tx_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             pause, push, pop, idle_ins;

  always_comb begin
    seq_d = '0;
    if (ENABLE) seq_d = (seq_q == SEQ_MAX7) ? 7'd0 : seq_q + 7'd1;
    pause    = ENABLE && (seq_d == SEQ_MAX7);
    push     = S_VALID && rdy_q;
    pop      = ENABLE && !pause && (cnt_q != 2'd0);
    idle_ins = ENABLE && !pause && (cnt_q == 2'd0);
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d    = (cnt_d < 2'd2);
  end

  // Head lives in slot 0; a pop shifts, and the new word lands after whatever remains.
  always_comb begin
    buf_d  = buf_q;
    wr_lvl = cnt_q - {1'b0, pop};
    if (pop) buf_d[0] = buf_q[1];
    if (push) buf_d[wr_lvl[0]] = '{hdr: S_HEADER, data: S_DATA};
  end

  always_comb begin
    tx_d       = tx_q;
    idle_cnt_d = idle_cnt_q;
    if (!ENABLE || idle_ins) tx_d = IDLE_WORD;
    else if (pop)            tx_d = buf_q[0];
    if (idle_ins && !(&idle_cnt_q)) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge USER_CLK) begin
    if (!SYSTEM_RESET_N) begin
      seq_q      <= '0;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      tx_q       <= '0;
      idle_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      buf_q      <= buf_d;
      tx_q       <= tx_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign S_READY     = rdy_q;
  assign TX_DATA     = tx_q.data;
  assign TX_HEADER   = tx_q.hdr;
  assign TX_SEQUENCE = seq_q;
  assign IDLE_CNT    = idle_cnt_q;

endmodule

// File: tb/tb_gt_tx_seq_ctrl.sv
// Directed bench for gt_tx_seq_ctrl; a second instance with a 4-bit idle counter covers saturation.
module tb_gt_tx_seq_ctrl;

  localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, en, s_valid, s_ready;
  logic [63:0] s_data, tx_data;
  logic [1:0]  s_hdr, tx_hdr;
  logic [6:0]  tx_seq;
  logic [15:0] idle_cnt;

  logic        rst4_n, en4, s_ready4;
  logic [63:0] tx_data4;
  logic [1:0]  tx_hdr4;
  logic [6:0]  tx_seq4;
  logic [3:0]  idle_cnt4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gt_tx_seq_ctrl dut (
    .USER_CLK(clk), .SYSTEM_RESET_N(rst_n), .ENABLE(en),
    .S_DATA(s_data), .S_HEADER(s_hdr), .S_VALID(s_valid), .S_READY(s_ready),
    .TX_DATA(tx_data), .TX_HEADER(tx_hdr), .TX_SEQUENCE(tx_seq), .IDLE_CNT(idle_cnt)
  );

  gt_tx_seq_ctrl #(.CNT_W(4)) dut4 (
    .USER_CLK(clk), .SYSTEM_RESET_N(rst4_n), .ENABLE(en4),
    .S_DATA(64'd0), .S_HEADER(2'b00), .S_VALID(1'b0), .S_READY(s_ready4),
    .TX_DATA(tx_data4), .TX_HEADER(tx_hdr4), .TX_SEQUENCE(tx_seq4), .IDLE_CNT(idle_cnt4)
  );

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b1; s_data = 64'hDEAD; s_hdr = 2'b01;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if (s_ready !== 1'b0 || tx_data !== 64'd0 || tx_hdr !== 2'b00 ||
          tx_seq !== 7'd0 || idle_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: rdy=%b data=%h hdr=%b seq=%0d idle=%0d, want all 0",
                 s_ready, tx_data, tx_hdr, tx_seq, idle_cnt);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n_chk++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", s_ready);
    end
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (tx_seq !== 7'd0 || tx_data !== IDLE || idle_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL disabled_idle: seq=%0d data=%h idle=%0d want 0/%h/0",
                 tx_seq, tx_data, idle_cnt, IDLE);
      end
    end
  endtask

  task automatic test_starvation();
    en = 1'b1; s_valid = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (i == 32) begin
        n_chk++;
        if (tx_seq !== 7'd32 || idle_cnt !== 16'd31) begin
          n_fail++; $display("FAIL starve_pause: seq=%0d idle=%0d want 32/31", tx_seq, idle_cnt);
        end
      end
    end
    n_chk++;
    if (idle_cnt !== 16'd64 || tx_data !== IDLE || tx_hdr !== 2'b10 || tx_seq !== 7'd0) begin
      n_fail++;
      $display("FAIL starve_end: idle=%0d data=%h hdr=%b seq=%0d want 64/%h/10/0",
               idle_cnt, tx_data, tx_hdr, tx_seq, IDLE);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] nxt_out, prev;
    logic        will_push;
    int acc = 0, emit = 0, lowcnt = 0, gaps = 0, pause_bad = 0, ord_bad = 0;
    nxt_out = 64'd1; prev = tx_data;
    s_data = 64'd1; s_hdr = 2'b01; s_valid = 1'b1;
    for (int i = 0; i < 335; i++) begin
      if (i == 330) s_valid = 1'b0;
      will_push = s_ready && s_valid;
      @(negedge clk);
      if (will_push) begin acc++; s_data = s_data + 64'd1; end
      if (i < 330 && !s_ready) lowcnt++;
      if (tx_seq == 7'd32 && tx_data !== prev) pause_bad++;
      if (tx_data !== prev && tx_data !== IDLE) begin
        if (tx_data !== nxt_out || tx_hdr !== 2'b01) ord_bad++;
        nxt_out = nxt_out + 64'd1;
        emit++;
      end
      if (i < 330 && emit > 0 && tx_data === IDLE) gaps++;
      prev = tx_data;
    end
    n_chk++;
    if (acc != 320) begin n_fail++; $display("FAIL stream_accepted: got %0d want 320", acc); end
    n_chk++;
    if (emit != 320) begin n_fail++; $display("FAIL stream_emitted: got %0d want 320", emit); end
    n_chk++;
    if (ord_bad != 0) begin n_fail++; $display("FAIL stream_order: %0d bad words want 0", ord_bad); end
    n_chk++;
    if (pause_bad != 0) begin n_fail++; $display("FAIL stream_pause_hold: %0d changes want 0", pause_bad); end
    n_chk++;
    if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: %0d idles want 0", gaps); end
    n_chk++;
    if (lowcnt != 10) begin n_fail++; $display("FAIL stream_ready_low: got %0d want 10", lowcnt); end
  endtask

  task automatic test_enable_drop();
    logic [15:0] base;
    en = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = 64'hAAAA_0000_0000_0001; s_hdr = 2'b01;
    @(negedge clk);
    s_data = 64'hBBBB_0000_0000_0002; s_hdr = 2'b00;
    @(negedge clk);
    s_valid = 1'b0;
    base = idle_cnt;
    n_chk++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL drop_full_ready: got %b want 0", s_ready); end
    repeat (10) begin
      @(negedge clk);
      n_chk++;
      if (tx_seq !== 7'd0 || tx_data !== IDLE || idle_cnt !== base) begin
        n_fail++;
        $display("FAIL drop_hold: seq=%0d data=%h idle=%0d want 0/%h/%0d",
                 tx_seq, tx_data, idle_cnt, IDLE, base);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_chk++;
    if (tx_data !== 64'hAAAA_0000_0000_0001 || tx_hdr !== 2'b01 || tx_seq !== 7'd1) begin
      n_fail++; $display("FAIL drop_word_a: data=%h hdr=%b seq=%0d", tx_data, tx_hdr, tx_seq);
    end
    @(negedge clk);
    n_chk++;
    if (tx_data !== 64'hBBBB_0000_0000_0002 || tx_hdr !== 2'b00) begin
      n_fail++; $display("FAIL drop_word_b: data=%h hdr=%b", tx_data, tx_hdr);
    end
    @(negedge clk);
    n_chk++;
    if (tx_data !== IDLE || idle_cnt !== base + 16'd1) begin
      n_fail++; $display("FAIL drop_after: data=%h idle=%0d want %h/%0d", tx_data, idle_cnt, IDLE, base + 16'd1);
    end
  endtask

  task automatic test_latency();
    for (int k = 0; k < 40 && tx_seq !== 7'd9; k++) @(negedge clk);
    n_chk++;
    if (tx_seq !== 7'd9) begin n_fail++; $display("FAIL lat_wait9: timeout seq=%0d", tx_seq); end
    s_valid = 1'b1; s_data = 64'h1234_5678_9ABC_DEF0; s_hdr = 2'b01;
    @(negedge clk);
    s_valid = 1'b0;
    n_chk++;
    if (tx_seq !== 7'd10 || tx_data !== IDLE) begin
      n_fail++; $display("FAIL lat_no_bypass: seq=%0d data=%h want 10/%h", tx_seq, tx_data, IDLE);
    end
    @(negedge clk);
    n_chk++;
    if (tx_seq !== 7'd11 || tx_data !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++; $display("FAIL lat_next_edge: seq=%0d data=%h want 11/123456789abcdef0", tx_seq, tx_data);
    end
    for (int k = 0; k < 40 && tx_seq !== 7'd31; k++) @(negedge clk);
    n_chk++;
    if (tx_seq !== 7'd31) begin n_fail++; $display("FAIL lat_wait31: timeout seq=%0d", tx_seq); end
    s_valid = 1'b1; s_data = 64'h0FED_CBA9_8765_4321; s_hdr = 2'b01;
    @(negedge clk);
    s_valid = 1'b0;
    n_chk++;
    if (tx_seq !== 7'd32 || tx_data !== IDLE) begin
      n_fail++; $display("FAIL lat_pause_hold: seq=%0d data=%h want 32/%h", tx_seq, tx_data, IDLE);
    end
    @(negedge clk);
    n_chk++;
    if (tx_seq !== 7'd0 || tx_data !== 64'h0FED_CBA9_8765_4321) begin
      n_fail++; $display("FAIL lat_after_pause: seq=%0d data=%h want 0/0fedcba987654321", tx_seq, tx_data);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b0;
    s_valid = 1'b1; s_data = 64'hC0C0_C0C0_C0C0_C0C0; s_hdr = 2'b01;
    @(negedge clk);
    s_data = 64'hD0D0_D0D0_D0D0_D0D0;
    @(negedge clk);
    s_valid = 1'b0;
    n_chk++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_ready: got %b want 0", s_ready); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (tx_data !== 64'd0 || s_ready !== 1'b0 || idle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_vals: data=%h rdy=%b idle=%0d", tx_data, s_ready, idle_cnt);
    end
    rst_n = 1'b1; en = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_chk++;
      if (tx_data !== IDLE || tx_hdr !== 2'b10) begin
        n_fail++; $display("FAIL mid_stale: data=%h hdr=%b want %h/10", tx_data, tx_hdr, IDLE);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    n_chk++;
    if (idle_cnt4 !== 4'h0) begin n_fail++; $display("FAIL sat_reset: got %h want 0", idle_cnt4); end
    rst4_n = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (idle_cnt4 !== 4'hA) begin n_fail++; $display("FAIL sat_count10: got %h want a", idle_cnt4); end
    repeat (30) @(negedge clk);
    n_chk++;
    if (idle_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h want f", idle_cnt4); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; s_hdr = '0;
    rst4_n = 1'b0; en4 = 1'b1;
    test_reset();
    test_starvation();
    test_streaming();
    test_enable_drop();
    test_latency();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
